match_sequencer: RTL and testbench

MATCH_SEQUENCER -- requirements
Module: match_sequencer

---
 rtl/tow_pkg.sv | 24 ++
 rtl/tick_timer.sv | 27 ++
 rtl/match_sequencer.sv | 108 ++++++++++
 tb/tb_match_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
// tow_pkg: shared state encoding, display codes and defaults for the match sequencer
package tow_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_PLAY,
      S_PAUSE,
      S_DONE
   } state_t;

   localparam logic [1:0] DISP_ROUND = 2'b00;
   localparam logic [1:0] DISP_SCORE = 2'b01;
   localparam logic [1:0] DISP_CHAMP = 2'b10;
   localparam logic [1:0] DISP_IDLE  = 2'b11;

   localparam int WINS_TO_TAKE_DEF = 3;
   localparam int PAUSE_TICKS_DEF  = 16;

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/tick_timer.sv
// tick_timer: loadable down-counter that steps on tick, stops at zero and flags it
module tick_timer #(
   parameter int TICKS = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic tick,
   output logic zero
);

   logic [7:0] cnt_q, cnt_d;

   // load beats tick, so a tick on the loading edge is never counted
   always_comb begin
      cnt_d = load ? 8'(TICKS) : (tick && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
   end

   // count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/match_sequencer.sv
// match_sequencer: runs a best-of match of rounds, tallying wins/ties and pacing rounds
module match_sequencer
   import tow_pkg::*;
#(
   parameter int WINS_TO_TAKE = WINS_TO_TAKE_DEF,
   parameter int PAUSE_TICKS  = PAUSE_TICKS_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       slowen,
   input  logic       rnd_done,
   input  logic       rnd_right,
   input  logic       rnd_tie,
   output logic       clear,
   output logic       rnd_start,
   output logic [2:0] left_wins,
   output logic [2:0] right_wins,
   output logic [3:0] tie_cnt,
   output logic       match_over,
   output logic       champ_right,
   output logic [1:0] disp_sel
);

   state_t     state_q, state_d;
   logic [2:0] left_q, left_d, right_q, right_d;
   logic [3:0] tie_q, tie_d;
   logic       champ_q, champ_d;
   logic [2:0] win_nxt;
   logic       pause_load, pause_zero;

   tick_timer #(.TICKS(PAUSE_TICKS)) u_pause (
      .clk  (clk),
      .rst  (rst),
      .load (pause_load),
      .tick (slowen && state_q == S_PAUSE),
      .zero (pause_zero)
   );

   // next state and score bookkeeping; counters move on the same edge as the state
   always_comb begin
      state_d    = state_q;
      left_d     = left_q;
      right_d    = right_q;
      tie_d      = tie_q;
      champ_d    = champ_q;
      pause_load = 1'b0;
      win_nxt    = (rnd_right ? right_q : left_q) + 3'd1;
      case (state_q)
         S_IDLE, S_DONE: if (start) begin
            left_d  = '0;
            right_d = '0;
            tie_d   = '0;
            champ_d = 1'b0;
            state_d = S_ARM;
         end
         S_ARM: state_d = S_PLAY;
         S_PLAY: if (rnd_done) begin
            if (rnd_tie) begin
               tie_d      = sat_inc4(tie_q);
               state_d    = S_PAUSE;
               pause_load = 1'b1;
            end else begin
               if (rnd_right) right_d = win_nxt;
               else           left_d  = win_nxt;
               if (win_nxt == 3'(WINS_TO_TAKE)) begin
                  state_d = S_DONE;
                  champ_d = rnd_right;
               end else begin
                  state_d    = S_PAUSE;
                  pause_load = 1'b1;
               end
            end
         end
         S_PAUSE: if (pause_zero) state_d = S_ARM;
         default: state_d = S_IDLE;
      endcase
   end

   // state and score registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         left_q  <= '0;
         right_q <= '0;
         tie_q   <= '0;
         champ_q <= 1'b0;
      end else begin
         state_q <= state_d;
         left_q  <= left_d;
         right_q <= right_d;
         tie_q   <= tie_d;
         champ_q <= champ_d;
      end
   end

   assign clear       = (state_q == S_ARM);
   assign rnd_start   = (state_q == S_ARM);
   assign left_wins   = left_q;
   assign right_wins  = right_q;
   assign tie_cnt     = tie_q;
   assign match_over  = (state_q == S_DONE);
   assign champ_right = champ_q;
   assign disp_sel    = (state_q == S_IDLE)  ? DISP_IDLE  :
                        (state_q == S_PAUSE) ? DISP_SCORE :
                        (state_q == S_DONE)  ? DISP_CHAMP : DISP_ROUND;

endmodule

// File: tb/tb_match_sequencer.sv
// tb_match_sequencer: table vectors, directed corner sequences and a randomized model check
module tb_match_sequencer;

   localparam int W  = 3;
   localparam int PT = 2;

   logic       clk, rst, start, slowen, rnd_done, rnd_right, rnd_tie;
   logic       clear, rnd_start, match_over, champ_right;
   logic [2:0] left_wins, right_wins;
   logic [3:0] tie_cnt;
   logic [1:0] disp_sel;

   int vecs = 0;
   int fails = 0;
   int rs_cnt = 0;

   match_sequencer #(.WINS_TO_TAKE(W), .PAUSE_TICKS(PT)) dut (
      .clk(clk), .rst(rst), .start(start), .slowen(slowen),
      .rnd_done(rnd_done), .rnd_right(rnd_right), .rnd_tie(rnd_tie),
      .clear(clear), .rnd_start(rnd_start), .left_wins(left_wins),
      .right_wins(right_wins), .tie_cnt(tie_cnt), .match_over(match_over),
      .champ_right(champ_right), .disp_sel(disp_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (rnd_start) rs_cnt++;

   typedef struct packed {
      logic [4:0] in;
      logic [1:0] pulse;
      logic [2:0] lw;
      logic [2:0] rw;
      logic [3:0] tc;
      logic [1:0] oc;
      logic [1:0] ds;
      logic       ad;
   } vec_t;

   vec_t tbl [20];

   int m_arm, m_play, m_wait, m_over, m_l, m_r, m_t, m_ch;

   task automatic chk(input string n, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic sl, input logic d, input logic r, input logic t);
      @(negedge clk);
      start = s; slowen = sl; rnd_done = d; rnd_right = r; rnd_tie = t;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      {start, slowen, rnd_done, rnd_right, rnd_tie} = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chk_reset(input string n);
      chk({n, ".clear"}, clear, 0);
      chk({n, ".rnd_start"}, rnd_start, 0);
      chk({n, ".left"}, left_wins, 0);
      chk({n, ".right"}, right_wins, 0);
      chk({n, ".tie"}, tie_cnt, 0);
      chk({n, ".over"}, match_over, 0);
      chk({n, ".champ"}, champ_right, 0);
      chk({n, ".disp"}, disp_sel, 3);
   endtask

   task automatic wait_play(input string n);
      int k;
      k = 0;
      while (!(disp_sel == 2'b00 && !rnd_start) && k < 40) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         k++;
      end
      if (k >= 40) chk({n, ".reach_play_timeout"}, 0, 1);
   endtask

   task automatic mreset();
      m_arm = 0; m_play = 0; m_wait = -1; m_over = 0;
      m_l = 0; m_r = 0; m_t = 0; m_ch = 0;
   endtask

   task automatic mstep(input logic s, input logic sl, input logic d, input logic r, input logic t);
      if (m_arm != 0) begin
         m_arm = 0; m_play = 1;
      end else if (m_play != 0) begin
         if (d) begin
            m_play = 0;
            if (t) begin
               m_t = (m_t < 15) ? m_t + 1 : 15;
               m_wait = PT;
            end else begin
               if (r) m_r++;
               else   m_l++;
               if ((r ? m_r : m_l) == W) begin
                  m_over = 1; m_ch = int'(r);
               end else m_wait = PT;
            end
         end
      end else if (m_wait >= 0) begin
         if (m_wait == 0) begin
            m_wait = -1; m_arm = 1;
         end else if (sl) m_wait--;
      end else if (s) begin
         m_l = 0; m_r = 0; m_t = 0; m_over = 0; m_ch = 0; m_arm = 1;
      end
   endtask

   task automatic mcheck();
      chk("rand.clear", clear, m_arm);
      chk("rand.rnd_start", rnd_start, m_arm);
      chk("rand.left", left_wins, m_l);
      chk("rand.right", right_wins, m_r);
      chk("rand.tie", tie_cnt, m_t);
      chk("rand.over", match_over, m_over);
      if (m_over != 0) chk("rand.champ", champ_right, m_ch);
      if (m_arm == 0)
         chk("rand.disp", disp_sel, (m_play != 0) ? 0 : (m_wait >= 0) ? 1 : (m_over != 0) ? 2 : 3);
   endtask

   initial begin
      int base;
      logic s, sl, d, r, t;
      rst = 1'b1;
      {start, slowen, rnd_done, rnd_right, rnd_tie} = '0;

      tbl[0]  = '{5'b10000, 2'b11, 3'd0, 3'd0, 4'd0, 2'b00, 2'b00, 1'b1};
      tbl[1]  = '{5'b00000, 2'b00, 3'd0, 3'd0, 4'd0, 2'b00, 2'b00, 1'b0};
      tbl[2]  = '{5'b00110, 2'b00, 3'd0, 3'd1, 4'd0, 2'b00, 2'b01, 1'b0};
      tbl[3]  = '{5'b10100, 2'b00, 3'd0, 3'd1, 4'd0, 2'b00, 2'b01, 1'b0};
      tbl[4]  = '{5'b01000, 2'b00, 3'd0, 3'd1, 4'd0, 2'b00, 2'b01, 1'b0};
      tbl[5]  = '{5'b01000, 2'b00, 3'd0, 3'd1, 4'd0, 2'b00, 2'b01, 1'b0};
      tbl[6]  = '{5'b00000, 2'b11, 3'd0, 3'd1, 4'd0, 2'b00, 2'b00, 1'b1};
      tbl[7]  = '{5'b00000, 2'b00, 3'd0, 3'd1, 4'd0, 2'b00, 2'b00, 1'b0};
      tbl[8]  = '{5'b01110, 2'b00, 3'd0, 3'd2, 4'd0, 2'b00, 2'b01, 1'b0};
      tbl[9]  = '{5'b00000, 2'b00, 3'd0, 3'd2, 4'd0, 2'b00, 2'b01, 1'b0};
      tbl[10] = '{5'b01000, 2'b00, 3'd0, 3'd2, 4'd0, 2'b00, 2'b01, 1'b0};
      tbl[11] = '{5'b01000, 2'b00, 3'd0, 3'd2, 4'd0, 2'b00, 2'b01, 1'b0};
      tbl[12] = '{5'b00000, 2'b11, 3'd0, 3'd2, 4'd0, 2'b00, 2'b00, 1'b1};
      tbl[13] = '{5'b00000, 2'b00, 3'd0, 3'd2, 4'd0, 2'b00, 2'b00, 1'b0};
      tbl[14] = '{5'b00110, 2'b00, 3'd0, 3'd3, 4'd0, 2'b11, 2'b10, 1'b0};
      tbl[15] = '{5'b00100, 2'b00, 3'd0, 3'd3, 4'd0, 2'b11, 2'b10, 1'b0};
      tbl[16] = '{5'b01000, 2'b00, 3'd0, 3'd3, 4'd0, 2'b11, 2'b10, 1'b0};
      tbl[17] = '{5'b10000, 2'b11, 3'd0, 3'd0, 4'd0, 2'b00, 2'b00, 1'b1};
      tbl[18] = '{5'b00000, 2'b00, 3'd0, 3'd0, 4'd0, 2'b00, 2'b00, 1'b0};
      tbl[19] = '{5'b00101, 2'b00, 3'd0, 3'd0, 4'd1, 2'b00, 2'b01, 1'b0};

      do_reset();
      chk_reset("reset");

      for (int i = 0; i < 20; i++) begin
         string n;
         n = $sformatf("tbl[%0d]", i);
         drive(tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
         chk({n, ".clear"}, clear, tbl[i].pulse[1]);
         chk({n, ".rnd_start"}, rnd_start, tbl[i].pulse[0]);
         chk({n, ".left"}, left_wins, tbl[i].lw);
         chk({n, ".right"}, right_wins, tbl[i].rw);
         chk({n, ".tie"}, tie_cnt, tbl[i].tc);
         chk({n, ".over"}, match_over, tbl[i].oc[1]);
         if (tbl[i].oc[1]) chk({n, ".champ"}, champ_right, tbl[i].oc[0]);
         if (!tbl[i].ad) chk({n, ".disp"}, disp_sel, tbl[i].ds);
      end

      do_reset();
      base = rs_cnt;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         wait_play("alt");
         drive(1'b0, 1'b0, 1'b1, (k % 2) == 1, 1'b0);
      end
      chk("alt.left", left_wins, 3);
      chk("alt.right", right_wins, 2);
      chk("alt.over", match_over, 1);
      chk("alt.champ", champ_right, 0);
      chk("alt.disp", disp_sel, 2);
      chk("alt.rnd_start_pulses", rs_cnt - base, 5);

      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++) begin
         wait_play("tie");
         drive(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
         chk($sformatf("tie[%0d].cnt", k), tie_cnt, (k < 15) ? k + 1 : 15);
      end
      chk("tie.left", left_wins, 0);
      chk("tie.right", right_wins, 0);
      chk("tie.disp", disp_sel, 1);
      wait_play("tie.again");
      chk("tie.over", match_over, 0);
      chk("tie.hold", tie_cnt, 15);

      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_play("async");
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("async.right_before", right_wins, 1);
      wait_play("async2");
      #2 rst = 1'b1;
      #1 chk_reset("async");
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("async.post_clear", clear, 0);
      chk("async.post_disp", disp_sel, 3);

      do_reset();
      mreset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset();
            mreset();
            chk_reset("rand.reset");
         end else begin
            s  = ($urandom_range(0, 7) == 0);
            sl = ($urandom_range(0, 1) == 0);
            d  = ($urandom_range(0, 3) == 0);
            r  = 1'($urandom_range(0, 1));
            t  = ($urandom_range(0, 3) == 0);
            drive(s, sl, d, r, t);
            mstep(s, sl, d, r, t);
            mcheck();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
